// File: rtl/qupls4_pkg.sv
// Shared types for the Qupls4 branch-miss unit.
// Provides the PC/stream types, branch kind, redirect FSM state,
// reset PC and a population-count helper for the stream free list.
package qupls4_pkg;

    localparam int unsigned ABITS   = 64;
    localparam int unsigned STREAMW = 7;
    localparam int unsigned CNTW    = 8;

    typedef logic [ABITS-1:0]   pc_address_t;
    typedef logic [STREAMW-1:0] pc_stream_t;

    typedef struct packed {
        pc_stream_t  stream;
        pc_address_t pc;
    } pc_address_ex_t;

    typedef enum logic [1:0] {
        BCC = 2'd0,
        BSR = 2'd1,
        JSR = 2'd2,
        RET = 2'd3
    } brkind_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        STALL = 2'd2
    } bm_state_t;

    localparam pc_address_t RSTPC = 64'hFFFF_FFFF_FFFC_0000;

    // Number of set bits in a vector of up to 128 bits.
    function automatic logic [CNTW-1:0] popcnt128(input logic [127:0] v);
        logic [CNTW-1:0] c;
        c = '0;
        for (int i = 0; i < 128; i++) begin
            c = c + CNTW'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/qupls4_branchmiss_unit_if.sv
// Bus bundle between the branch-resolution channels / fetch and the
// branch-miss unit.
//   br_*      : per-channel resolved-branch reports with br_ready consume
//   rel_*     : stream-release strobe
//   miss_*    : redirect toward fetch with valid/ready handshake
//   free_cnt  : number of free PC streams
// master = report/fetch side, slave = branch-miss unit.
interface qupls4_branchmiss_unit_if
    import qupls4_pkg::*;
#(
    parameter int unsigned NCH  = 2,
    parameter int unsigned SEQW = 8
) ();

    logic [NCH-1:0]             br_v;
    logic [NCH-1:0]             br_ready;
    brkind_t [NCH-1:0]          br_kind;
    logic [NCH-1:0]             br_bt;
    logic [NCH-1:0]             br_takb;
    pc_address_ex_t [NCH-1:0]   br_pc;
    logic [NCH-1:0][63:0]       br_disp;
    pc_address_t [NCH-1:0]      br_tgt;
    logic [NCH-1:0][SEQW-1:0]   br_seq;

    logic                       rel_v;
    pc_stream_t                 rel_stream;

    logic                       miss_v;
    logic                       miss_ready;
    pc_address_ex_t             miss_pc;
    logic [SEQW-1:0]            miss_seq;
    pc_stream_t                 miss_kept_stream;
    logic [CNTW-1:0]            free_cnt;

    modport master (
        output br_v, br_kind, br_bt, br_takb, br_pc, br_disp, br_tgt, br_seq,
        output rel_v, rel_stream, miss_ready,
        input  br_ready, miss_v, miss_pc, miss_seq, miss_kept_stream, free_cnt
    );

    modport slave (
        input  br_v, br_kind, br_bt, br_takb, br_pc, br_disp, br_tgt, br_seq,
        input  rel_v, rel_stream, miss_ready,
        output br_ready, miss_v, miss_pc, miss_seq, miss_kept_stream, free_cnt
    );

endinterface

// File: rtl/qupls4_stream_freelist.sv
// PC stream free list.
// Ports:
//   clk, rst        : clock, async active-high reset
//   alloc           : take the lowest free stream this cycle
//   rel_v/rel_stream: external release of a stream
//   drop_v/drop_stream: release of an overwritten pending miss's stream
//   avail_c         : a free stream exists (pre-release view)
//   alloc_stream_c  : lowest-numbered free stream (pre-release view)
//   free_cnt        : registered count of free streams
module qupls4_stream_freelist
    import qupls4_pkg::*;
#(
    parameter int unsigned NSTREAM = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alloc,
    input  logic            rel_v,
    input  pc_stream_t      rel_stream,
    input  logic            drop_v,
    input  pc_stream_t      drop_stream,
    output logic            avail_c,
    output pc_stream_t      alloc_stream_c,
    output logic [CNTW-1:0] free_cnt
);

    // Streams 0 and 1 are busy out of reset; stream 0 is never handed out.
    localparam logic [NSTREAM-1:0] FREE_RST = ~NSTREAM'(3);

    logic [NSTREAM-1:0] free_q;
    logic [NSTREAM-1:0] free_d;
    logic [NSTREAM-1:0] rel_mask;
    logic [NSTREAM-1:0] drop_mask;
    logic [NSTREAM-1:0] alloc_mask;

    // Lowest free stream from the current (pre-release) bitmap.
    always_comb begin
        avail_c        = 1'b0;
        alloc_stream_c = '0;
        for (int i = NSTREAM - 1; i >= 1; i--) begin
            if (free_q[i]) begin
                avail_c        = 1'b1;
                alloc_stream_c = STREAMW'(i);
            end
        end
    end

    // Releases of stream 0, out-of-range or already-free streams never match.
    always_comb begin
        rel_mask   = '0;
        drop_mask  = '0;
        alloc_mask = '0;
        for (int i = 1; i < NSTREAM; i++) begin
            rel_mask[i]   = rel_v && (rel_stream == STREAMW'(i)) && !free_q[i];
            drop_mask[i]  = drop_v && (drop_stream == STREAMW'(i)) && !free_q[i];
            alloc_mask[i] = alloc && avail_c && (alloc_stream_c == STREAMW'(i));
        end
        free_d = (free_q | rel_mask | drop_mask) & ~alloc_mask;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            free_q   <= FREE_RST;
            free_cnt <= CNTW'(NSTREAM - 2);
        end else begin
            free_q   <= free_d;
            free_cnt <= popcnt128(128'(free_d));
        end
    end

endmodule

// File: rtl/qupls4_branchmiss_unit.sv
// Branch-miss unit: collects resolved-branch reports from NCH channels,
// picks the oldest mispredicted/redirecting branch, allocates a new PC
// stream where needed and presents a single redirect toward fetch.
// Ports:
//   clk, rst : clock, async active-high reset
//   bus      : slave side of qupls4_branchmiss_unit_if (br_*, rel_*,
//              miss_*, free_cnt)
module qupls4_branchmiss_unit
    import qupls4_pkg::*;
#(
    parameter int unsigned NCH     = 2,
    parameter int unsigned NSTREAM = 32,
    parameter int unsigned SEQW    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    qupls4_branchmiss_unit_if.slave    bus
);

    localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;

    // a is older than b when (a-b) has its top bit set (wrapping sequence).
    function automatic logic older(input logic [SEQW-1:0] a, input logic [SEQW-1:0] b);
        logic [SEQW-1:0] d;
        d = a - b;
        return d[SEQW-1];
    endfunction

    bm_state_t       state_q;
    bm_state_t       state_d;

    pc_address_t     tgt_c [NCH];
    logic [NCH-1:0]  miss_c;
    logic [NCH-1:0]  hit_c;
    logic [NCH-1:0]  ready_c;

    logic            cand_v;
    logic [CHW-1:0]  cand_ch;
    logic [SEQW-1:0] cand_seq;
    pc_address_t     cand_tgt;
    brkind_t         cand_kind;
    pc_stream_t      cand_stream;

    logic            pend;
    logic            hs;
    logic            need;
    logic            age_ok;
    logic            accept;
    logic            blocked;

    logic            fl_avail;
    pc_stream_t      fl_stream;
    logic            fl_alloc;
    logic            drop_v;
    logic [CNTW-1:0] fl_cnt;

    logic            miss_v_q;
    pc_address_ex_t  miss_pc_q;
    logic [SEQW-1:0] miss_seq_q;
    pc_stream_t      kept_q;
    pc_stream_t      pend_alloc_q;

    // Per-channel target and miss classification; arithmetic wraps at ABITS.
    always_comb begin
        for (int n = 0; n < NCH; n++) begin
            miss_c[n] = bus.br_v[n] &&
                        ((bus.br_kind[n] != BCC) || (bus.br_bt[n] != bus.br_takb[n]));
            hit_c[n]  = bus.br_v[n] && !miss_c[n];
            case (bus.br_kind[n])
                BCC:     tgt_c[n] = bus.br_takb[n] ? bus.br_pc[n].pc + bus.br_disp[n]
                                                   : bus.br_pc[n].pc + ABITS'(6);
                BSR:     tgt_c[n] = bus.br_pc[n].pc + bus.br_disp[n];
                JSR:     tgt_c[n] = bus.br_disp[n];
                default: tgt_c[n] = bus.br_tgt[n];
            endcase
        end
    end

    // Oldest valid miss; strict compare keeps the lowest channel on a tie.
    always_comb begin
        cand_v      = 1'b0;
        cand_ch     = '0;
        cand_seq    = '0;
        cand_tgt    = '0;
        cand_kind   = BCC;
        cand_stream = '0;
        for (int n = 0; n < NCH; n++) begin
            if (miss_c[n] && (!cand_v || older(bus.br_seq[n], cand_seq))) begin
                cand_v      = 1'b1;
                cand_ch     = CHW'(n);
                cand_seq    = bus.br_seq[n];
                cand_tgt    = tgt_c[n];
                cand_kind   = bus.br_kind[n];
                cand_stream = bus.br_pc[n].stream;
            end
        end
    end

    // Accept decision: must beat the pending miss and have a stream if it needs one.
    assign pend    = (state_q == PEND);
    assign hs      = miss_v_q && bus.miss_ready;
    assign need    = (cand_kind != RET);
    assign age_ok  = !pend || older(cand_seq, miss_seq_q);
    assign accept  = cand_v && age_ok && (!need || fl_avail);
    assign blocked = cand_v && age_ok && need && !fl_avail;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, STALL: begin
                if (accept) begin
                    state_d = PEND;
                end else if (blocked) begin
                    state_d = STALL;
                end else begin
                    state_d = IDLE;
                end
            end
            PEND: begin
                if (accept) begin
                    state_d = PEND;
                end else if (hs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: consume, discard wrong-path misses, drive the free list.
    always_comb begin
        ready_c  = '0;
        fl_alloc = accept && need;
        // Overwriting a pending miss that was not handed to fetch returns its stream.
        drop_v   = accept && pend && !hs && (pend_alloc_q != '0);
        for (int n = 0; n < NCH; n++) begin
            ready_c[n] = hit_c[n] ||
                         (accept && (cand_ch == CHW'(n))) ||
                         (miss_c[n] && ((pend && older(miss_seq_q, bus.br_seq[n])) ||
                                        (accept && older(cand_seq, bus.br_seq[n]))));
        end
    end

    assign bus.br_ready = rst ? '0 : ready_c;

    // Redirect payload, loaded on accept and held until the next accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miss_v_q     <= 1'b0;
            miss_pc_q    <= '{stream: STREAMW'(1), pc: RSTPC};
            miss_seq_q   <= '0;
            kept_q       <= '0;
            pend_alloc_q <= '0;
        end else begin
            miss_v_q <= (state_d == PEND);
            if (accept) begin
                miss_pc_q.pc     <= cand_tgt;
                miss_pc_q.stream <= need ? fl_stream : cand_stream;
                miss_seq_q       <= cand_seq;
                kept_q           <= (cand_kind == BCC) ? cand_stream : '0;
                pend_alloc_q     <= need ? fl_stream : '0;
            end
        end
    end

    assign bus.miss_v           = miss_v_q;
    assign bus.miss_pc          = miss_pc_q;
    assign bus.miss_seq         = miss_seq_q;
    assign bus.miss_kept_stream = kept_q;
    assign bus.free_cnt         = fl_cnt;

    qupls4_stream_freelist #(
        .NSTREAM (NSTREAM)
    ) u_freelist (
        .clk            (clk),
        .rst            (rst),
        .alloc          (fl_alloc),
        .rel_v          (bus.rel_v),
        .rel_stream     (bus.rel_stream),
        .drop_v         (drop_v),
        .drop_stream    (pend_alloc_q),
        .avail_c        (fl_avail),
        .alloc_stream_c (fl_stream),
        .free_cnt       (fl_cnt)
    );

endmodule

// File: tb/tb_qupls4_branchmiss_unit.sv
// Self-checking bench for qupls4_branchmiss_unit: directed table, corner
// sequences and randomized traffic against a behavioural model.
module tb_qupls4_branchmiss_unit;
    import qupls4_pkg::*;

    localparam int unsigned NCH     = 2;
    localparam int unsigned NSTREAM = 32;
    localparam int unsigned SEQW    = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    qupls4_branchmiss_unit_if #(.NCH(NCH), .SEQW(SEQW)) bus ();

    qupls4_branchmiss_unit #(.NCH(NCH), .NSTREAM(NSTREAM), .SEQW(SEQW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit          m_free [NSTREAM];
    bit          m_pv;
    logic [63:0] m_pc;
    int          m_stream, m_seq, m_kept, m_alloc;
    bit          n_free [NSTREAM];
    bit          n_pv;
    logic [63:0] n_pc;
    int          n_stream, n_seq, n_kept, n_alloc;
    logic [NCH-1:0] m_ready;
    logic [NCH-1:0] last_ready;

    typedef struct {
        brkind_t     kind;
        bit          bt;
        bit          tk;
        logic [63:0] pc;
        logic [63:0] disp;
        logic [63:0] tgt;
        bit          exp_mv;
        logic [63:0] exp_pc;
        int          exp_stream;
        int          exp_kept;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit is_older(input int a, input int b);
        return ((a - b) & ((1 << SEQW) - 1)) >= (1 << (SEQW - 1));
    endfunction

    function automatic int free_count();
        int c = 0;
        for (int s = 0; s < NSTREAM; s++) c += int'(m_free[s]);
        return c;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < NSTREAM; s++) m_free[s] = (s >= 2);
        m_pv = 0; m_pc = RSTPC; m_stream = 1; m_seq = 0; m_kept = 0; m_alloc = 0;
    endtask

    // Evaluate one cycle of the rules against the current inputs.
    task automatic model_eval();
        logic [63:0] tg [NCH];
        bit          ms [NCH];
        int          cand = -1;
        int          lf = 0;
        int          a;
        bit          hs, acc, ret_k;
        for (int n = 0; n < NCH; n++) begin
            ms[n] = bus.br_v[n] && (bus.br_kind[n] != BCC || bus.br_bt[n] != bus.br_takb[n]);
            case (bus.br_kind[n])
                BCC: tg[n] = bus.br_takb[n] ? bus.br_pc[n].pc + bus.br_disp[n] : bus.br_pc[n].pc + 64'd6;
                BSR: tg[n] = bus.br_pc[n].pc + bus.br_disp[n];
                JSR: tg[n] = bus.br_disp[n];
                default: tg[n] = bus.br_tgt[n];
            endcase
            if (ms[n] && (cand < 0 || is_older(int'(bus.br_seq[n]), int'(bus.br_seq[cand])))) cand = n;
        end
        for (int s = 1; s < NSTREAM; s++) if (m_free[s] && lf == 0) lf = s;
        hs = m_pv && bus.miss_ready;
        ret_k = (cand >= 0) && (bus.br_kind[cand] == RET);
        acc = (cand >= 0) && (!m_pv || is_older(int'(bus.br_seq[cand]), m_seq)) && (ret_k || lf != 0);
        for (int n = 0; n < NCH; n++) begin
            m_ready[n] = (bus.br_v[n] && !ms[n]) || (acc && n == cand) ||
                         (ms[n] && ((m_pv && is_older(m_seq, int'(bus.br_seq[n]))) ||
                                    (acc && is_older(int'(bus.br_seq[cand]), int'(bus.br_seq[n])))));
        end
        n_free = m_free; n_pv = m_pv; n_pc = m_pc; n_stream = m_stream;
        n_seq = m_seq; n_kept = m_kept; n_alloc = m_alloc;
        if (acc) begin
            if (m_pv && !hs && m_alloc != 0) n_free[m_alloc] = 1;
            a = ret_k ? 0 : lf;
            if (a != 0) n_free[a] = 0;
            n_pv = 1;
            n_pc = tg[cand];
            n_stream = (a != 0) ? a : int'(bus.br_pc[cand].stream);
            n_seq = int'(bus.br_seq[cand]);
            n_kept = (bus.br_kind[cand] == BCC) ? int'(bus.br_pc[cand].stream) : 0;
            n_alloc = a;
        end else if (hs) begin
            n_pv = 0;
        end
        if (bus.rel_v && bus.rel_stream >= 1 && int'(bus.rel_stream) < NSTREAM && !m_free[bus.rel_stream])
            n_free[bus.rel_stream] = 1;
    endtask

    // One clock: check br_ready mid-cycle, then registered outputs after the edge.
    task automatic step();
        @(negedge clk);
        model_eval();
        last_ready = bus.br_ready;
        chk("br_ready", 64'(bus.br_ready), 64'(m_ready));
        @(posedge clk);
        #1;
        m_free = n_free; m_pv = n_pv; m_pc = n_pc; m_stream = n_stream;
        m_seq = n_seq; m_kept = n_kept; m_alloc = n_alloc;
        chk("miss_v", 64'(bus.miss_v), 64'(m_pv));
        chk("miss_pc.pc", bus.miss_pc.pc, m_pc);
        chk("miss_pc.stream", 64'(bus.miss_pc.stream), 64'(m_stream));
        chk("miss_seq", 64'(bus.miss_seq), 64'(m_seq));
        chk("miss_kept_stream", 64'(bus.miss_kept_stream), 64'(m_kept));
        chk("free_cnt", 64'(bus.free_cnt), 64'(free_count()));
    endtask

    task automatic clear_in();
        bus.br_v = '0; bus.br_kind = '0; bus.br_bt = '0; bus.br_takb = '0;
        bus.br_pc = '0; bus.br_disp = '0; bus.br_tgt = '0; bus.br_seq = '0;
        bus.rel_v = 0; bus.rel_stream = '0; bus.miss_ready = 0;
    endtask

    task automatic set_ch(input int n, input brkind_t k, input bit bt, input bit tk,
                          input logic [63:0] pc, input int strm, input logic [63:0] disp,
                          input logic [63:0] tgt, input int seq);
        bus.br_v[n] = 1; bus.br_kind[n] = k; bus.br_bt[n] = bt; bus.br_takb[n] = tk;
        bus.br_pc[n].pc = pc; bus.br_pc[n].stream = 7'(strm);
        bus.br_disp[n] = disp; bus.br_tgt[n] = tgt; bus.br_seq[n] = 8'(seq);
    endtask

    task automatic handshake_release(input int strm);
        clear_in();
        bus.miss_ready = 1;
        bus.rel_v = (strm > 1);
        bus.rel_stream = 7'(strm);
        step();
        clear_in();
    endtask

    initial begin
        vecs[0] = '{BCC, 1'b0, 1'b1, 64'h1000, 64'h40, 64'h0, 1'b1, 64'h1040, 2, 1};
        vecs[1] = '{BCC, 1'b1, 1'b0, 64'h2000, 64'h40, 64'h0, 1'b1, 64'h2006, 2, 1};
        vecs[2] = '{BCC, 1'b1, 1'b1, 64'h2000, 64'h40, 64'h0, 1'b0, 64'h0, 0, 0};
        vecs[3] = '{BSR, 1'b0, 1'b0, 64'h3000, 64'hFFFF_FFFF_FFFF_FF00, 64'h0, 1'b1, 64'h2F00, 2, 0};
        vecs[4] = '{JSR, 1'b0, 1'b0, 64'h4000, 64'h1234_5678, 64'h0, 1'b1, 64'h1234_5678, 2, 0};
        vecs[5] = '{RET, 1'b0, 1'b0, 64'h5000, 64'h0, 64'hABCD_EF0, 1'b1, 64'hABCD_EF0, 1, 0};
        vecs[6] = '{BSR, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 64'h0, 1'b1, 64'h10, 2, 0};
        vecs[7] = '{BCC, 1'b0, 1'b0, 64'h6000, 64'h40, 64'h0, 1'b0, 64'h0, 0, 0};

        // Reset state, with a report present that must not be consumed.
        rst = 1;
        clear_in();
        set_ch(0, BCC, 1'b1, 1'b1, 64'h100, 1, 64'h0, 64'h0, 0);
        model_reset();
        #1;
        chk("rst br_ready", 64'(bus.br_ready), 64'h0);
        chk("rst miss_v", 64'(bus.miss_v), 64'h0);
        chk("rst miss_pc.pc", bus.miss_pc.pc, RSTPC);
        chk("rst miss_pc.stream", 64'(bus.miss_pc.stream), 64'd1);
        chk("rst miss_seq", 64'(bus.miss_seq), 64'd0);
        chk("rst free_cnt", 64'(bus.free_cnt), 64'(NSTREAM - 2));
        @(negedge clk);
        rst = 0;
        clear_in();
        @(posedge clk);
        #1;

        // Directed single-report table.
        for (int i = 0; i < 8; i++) begin
            clear_in();
            set_ch(0, vecs[i].kind, vecs[i].bt, vecs[i].tk, vecs[i].pc, 1, vecs[i].disp, vecs[i].tgt, 1);
            step();
            chk($sformatf("vec%0d ready", i), 64'(last_ready[0]), 64'd1);
            chk($sformatf("vec%0d miss_v", i), 64'(bus.miss_v), 64'(vecs[i].exp_mv));
            if (vecs[i].exp_mv) begin
                chk($sformatf("vec%0d pc", i), bus.miss_pc.pc, vecs[i].exp_pc);
                chk($sformatf("vec%0d stream", i), 64'(bus.miss_pc.stream), 64'(vecs[i].exp_stream));
                chk($sformatf("vec%0d kept", i), 64'(bus.miss_kept_stream), 64'(vecs[i].exp_kept));
            end
            handshake_release(vecs[i].exp_mv ? vecs[i].exp_stream : 0);
        end

        // Two channels missing together: older ch1 wins, ch0 discarded.
        set_ch(0, BCC, 1'b0, 1'b1, 64'h7000, 1, 64'h10, 64'h0, 5);
        set_ch(1, BSR, 1'b0, 1'b0, 64'h8000, 1, 64'h20, 64'h0, 3);
        step();
        chk("pair ready", 64'(last_ready), 64'h3);
        chk("pair seq", 64'(bus.miss_seq), 64'd3);
        chk("pair pc", bus.miss_pc.pc, 64'h8020);
        handshake_release(2);

        // Older miss overwrites a pending one and recycles its stream.
        set_ch(0, BCC, 1'b0, 1'b1, 64'h9000, 1, 64'h8, 64'h0, 10);
        step();
        chk("ovr first stream", 64'(bus.miss_pc.stream), 64'd2);
        chk("ovr first cnt", 64'(bus.free_cnt), 64'(NSTREAM - 3));
        set_ch(0, BCC, 1'b0, 1'b1, 64'hA000, 1, 64'h8, 64'h0, 8);
        step();
        chk("ovr seq", 64'(bus.miss_seq), 64'd8);
        chk("ovr stream", 64'(bus.miss_pc.stream), 64'd3);
        chk("ovr cnt", 64'(bus.free_cnt), 64'(NSTREAM - 3));
        set_ch(0, BCC, 1'b0, 1'b1, 64'hB000, 1, 64'h8, 64'h0, 12);
        step();
        chk("younger discard ready", 64'(last_ready[0]), 64'd1);
        chk("younger keeps seq", 64'(bus.miss_seq), 64'd8);
        handshake_release(3);

        // Sequence wrap: 0xFE is older than pending 0x02.
        set_ch(0, BSR, 1'b0, 1'b0, 64'hC000, 1, 64'h4, 64'h0, 8'h02);
        step();
        set_ch(0, JSR, 1'b0, 1'b0, 64'hD000, 1, 64'hE000, 64'h0, 8'hFE);
        step();
        chk("wrap ready", 64'(last_ready[0]), 64'd1);
        chk("wrap seq", 64'(bus.miss_seq), 64'hFE);
        chk("wrap pc", bus.miss_pc.pc, 64'hE000);
        handshake_release(3);
        handshake_release(2);

        // Exhaust the free list, then stall until a stream is released.
        for (int i = 0; i < int'(NSTREAM) - 2; i++) begin
            set_ch(0, BCC, 1'b0, 1'b1, 64'h10000, 1, 64'h4, 64'h0, i);
            step();
            handshake_release(0);
        end
        chk("exhausted cnt", 64'(bus.free_cnt), 64'd0);
        set_ch(0, BSR, 1'b0, 1'b0, 64'h20000, 1, 64'h100, 64'h0, 8'h40);
        step();
        chk("stall ready", 64'(last_ready[0]), 64'd0);
        chk("stall miss_v", 64'(bus.miss_v), 64'd0);
        bus.rel_v = 1; bus.rel_stream = 7'd4;
        step();
        chk("stall rel ready", 64'(last_ready[0]), 64'd0);
        bus.rel_v = 0;
        step();
        chk("unstall ready", 64'(last_ready[0]), 64'd1);
        chk("unstall miss_v", 64'(bus.miss_v), 64'd1);
        chk("unstall stream", 64'(bus.miss_pc.stream), 64'd4);
        chk("unstall pc", bus.miss_pc.pc, 64'h20100);
        handshake_release(0);
        for (int s = 2; s < int'(NSTREAM); s++) begin
            bus.rel_v = 1; bus.rel_stream = 7'(s);
            step();
        end
        clear_in();
        chk("refill cnt", 64'(bus.free_cnt), 64'(NSTREAM - 2));

        // Asynchronous reset while a miss is pending.
        set_ch(0, BSR, 1'b0, 1'b0, 64'h30000, 1, 64'h8, 64'h0, 1);
        step();
        chk("pre-rst miss_v", 64'(bus.miss_v), 64'd1);
        clear_in();
        set_ch(0, BCC, 1'b1, 1'b1, 64'h100, 1, 64'h0, 64'h0, 0);
        rst = 1;
        #1;
        chk("async rst miss_v", 64'(bus.miss_v), 64'd0);
        chk("async rst free_cnt", 64'(bus.free_cnt), 64'(NSTREAM - 2));
        chk("async rst br_ready", 64'(bus.br_ready), 64'd0);
        model_reset();
        clear_in();
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            for (int n = 0; n < NCH; n++) begin
                bus.br_v[n]          = ($urandom_range(0, 2) != 0);
                bus.br_kind[n]       = brkind_t'($urandom_range(0, 3));
                bus.br_bt[n]         = 1'($urandom);
                bus.br_takb[n]       = 1'($urandom);
                bus.br_pc[n].pc      = {32'($urandom), 32'($urandom)};
                bus.br_pc[n].stream  = 7'($urandom_range(1, NSTREAM - 1));
                bus.br_disp[n]       = {32'($urandom), 32'($urandom)};
                bus.br_tgt[n]        = {32'($urandom), 32'($urandom)};
                bus.br_seq[n]        = 8'($urandom);
            end
            bus.miss_ready = ($urandom_range(0, 3) != 0);
            bus.rel_v      = ($urandom_range(0, 1) != 0);
            bus.rel_stream = 7'($urandom_range(0, 40));
            step();
        end
        clear_in();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/qupls4_branchmiss_unit.md
QUPLS4_BRANCHMISS_UNIT -- requirements
Module: Qupls4_branchmiss_unit

Interface
REQ-001 SHALL have parameter NCH, default 2: number of branch-resolution channels.
REQ-002 SHALL have parameter NSTREAM, default 32 (max 128): number of PC stream IDs; pc_stream_t is 7 bits.
REQ-003 SHALL have parameter SEQW, default 8: width of the instruction sequence number.
REQ-004 SHALL have port clk  input  1: the single clock; all state is updated on its rising edge.
REQ-005 SHALL have port rst  input  1: asynchronous, active-high reset.
REQ-006 SHALL have port br_v  input  NCH: channel n is reporting a resolved branch.
REQ-007 SHALL have port br_ready  output  NCH: the channel-n report is consumed this cycle.
REQ-008 SHALL have port br_kind  input  NCH x brkind_t: branch kind, one of BCC, BSR, JSR or RET.
REQ-009 SHALL have port br_bt  input  NCH: predicted taken.
REQ-010 SHALL have port br_takb  input  NCH: resolved taken.
REQ-011 SHALL have port br_pc  input  NCH x pc_address_ex_t: the branch PC and its stream.
REQ-012 SHALL have port br_disp  input  NCH x 64: sign-extended displacement, already scaled.
REQ-013 SHALL have port br_tgt  input  NCH x pc_address_t: register (return) target.
REQ-014 SHALL have port br_seq  input  NCH x SEQW: branch sequence number.
REQ-015 SHALL have port rel_v  input  1: stream-release strobe.
REQ-016 SHALL have port rel_stream  input  7: the stream being released.
REQ-017 SHALL have port miss_v  output  1: a redirect is pending toward fetch.
REQ-018 SHALL have port miss_ready  input  1: fetch accepts the redirect.
REQ-019 SHALL have port miss_pc  output  pc_address_ex_t: the redirect PC and stream.
REQ-020 SHALL have port miss_seq  output  SEQW: sequence number of the missing branch.
REQ-021 SHALL have port miss_kept_stream  output  7: the stream kept alive, 0 if none.
REQ-022 SHALL have port free_cnt  output  8: number of free streams.

Function
REQ-023 SHALL compute the per-channel target as follows:
- BCC taken: pc+disp.
- BCC not taken: pc+6.
- BSR: pc+disp.
- JSR: disp.
- RET: tgt.
REQ-024 SHALL classify a report as a miss when it is BCC with bt!=takb, or any BSR, JSR or RET; a BCC with bt==takb SHALL get br_ready=1 and have no other effect.
REQ-025 SHALL allocate a new stream for BCC, BSR and JSR misses; a RET miss SHALL keep br_pc.stream.
- miss_kept_stream SHALL be br_pc.stream for a BCC miss, otherwise 0.
REQ-026 SHALL define age as: a is older than b iff bit SEQW-1 of (a-b) is 1.
REQ-027 SHALL select, among valid misses, the oldest one; on equal age the lowest channel index wins.
REQ-028 SHALL accept the selected miss only if the candidate is older than the pending miss (or none is pending), and it either needs no stream or a free stream exists.
REQ-029 SHALL consume and discard (br_ready=1) any miss that is younger than the pending or the accepted miss.
- Any other unaccepted miss SHALL get br_ready=0.
REQ-030 SHALL run an FSM with three states, IDLE, PEND and STALL:
- IDLE->PEND on accept.
- IDLE->STALL when a candidate is blocked only by an empty free list.
- STALL->PEND when a stream frees.
- PEND->IDLE on miss_v&miss_ready with no accept in the same cycle.
REQ-031 SHALL present an accepted miss on miss_* in the cycle after the accept (1-cycle latency), held stable until handshake.
REQ-032 SHALL, when accepting an older miss while in PEND with no handshake in the same cycle, overwrite the pending miss and free the overwritten miss's allocated stream in that same cycle.
REQ-033 SHALL, on handshake and accept in the same cycle, transfer the old miss and make the new one pending, without freeing the old miss's stream.
REQ-034 SHALL allocate the lowest-numbered free stream from a NSTREAM-bit bitmap.
- The allocation SHALL use the pre-release bitmap.
- Stream 0 SHALL never be allocated.
REQ-035 SHALL on rel_v free rel_stream; a release of stream 0, a stream >= NSTREAM, or an already-free stream SHALL be ignored.
REQ-036 SHALL drive free_cnt as the registered population count of free streams.

Reset
REQ-037 SHALL on rst asynchronously force the following, including in the middle of an operation:
- State IDLE; miss_v=0.
- miss_pc.pc=RSTPC and miss_pc.stream=1.
- miss_seq=0; miss_kept_stream=0.
- Bitmap with streams 0 and 1 busy and all others free; free_cnt=NSTREAM-2.
REQ-038 SHALL drive br_ready=0 while rst is asserted.

Structure
REQ-039 SHALL have brkind_t and the FSM state enum defined in Qupls4_pkg, with RSTPC reused from that package.
REQ-040 SHALL implement the free list in one sub-module, Qupls4_stream_freelist (alloc, release, count).
REQ-041 SHALL keep all target arithmetic ABITS-wide, with carry-out discarded (wraps modulo 2^ABITS).

Verification
REQ-042 SHALL test: ch0 BCC, bt=0, takb=1, pc=0x1000, disp=0x40, stream 1 -> next cycle miss_pc.pc=0x1040, miss_pc.stream=2, miss_kept_stream=1.
REQ-043 SHALL test: ch0 seq 5 and ch1 seq 3 both missing in the same cycle -> ch1 accepted; ch0 discarded with br_ready=1.
REQ-044 SHALL test: miss seq 10 pending (miss_ready=0), then a miss with seq 8 -> pending replaced, stream freed, free_cnt unchanged.
REQ-045 SHALL test: all streams allocated, BSR reported -> STALL with br_ready=0; then rel_v for stream 4 -> accepted next cycle with miss_pc.stream=4.
REQ-046 SHALL test: seq wrap, pending seq 0x02 and new seq 0xFE -> new miss treated as older and accepted.
REQ-047 SHALL test: rst pulsed in PEND -> miss_v=0 immediately and free_cnt=NSTREAM-2.
